// File: rtl/time_count24_if.sv
// time_count24_if: control inputs and digit outputs of the 24-hour BCD time counter.
// master drives the 1 Hz tick, hold, set buttons and display select; slave is the counter.
interface time_count24_if;
    logic       ENABLE_Hz;
    logic       HOLD;
    logic       INC_MIN;
    logic       INC_HOUR;
    logic       DISP_SEL;
    logic [3:0] L1;
    logic [3:0] L2;
    logic [3:0] L3;
    logic [3:0] L4;
    logic       COLON;
    logic       DAY_PULSE;
    modport master (
        output ENABLE_Hz, HOLD, INC_MIN, INC_HOUR, DISP_SEL,
        input  L1, L2, L3, L4, COLON, DAY_PULSE
    );
    modport slave (
        input  ENABLE_Hz, HOLD, INC_MIN, INC_HOUR, DISP_SEL,
        output L1, L2, L3, L4, COLON, DAY_PULSE
    );
endinterface

// File: rtl/time_count24.sv
// time_count24: BCD HH:MM:SS counter with hold, manual minute/hour set,
// HH:MM / MM:SS digit mux, colon blink and registered end-of-day pulse.
module time_count24 #(
    parameter logic [7:0] INIT_HH = 8'h00,
    parameter logic [7:0] INIT_MM = 8'h00
) (
    input  logic          CLK,
    input  logic          RESET,
    time_count24_if.slave bus
);
    logic [3:0] r_s_u, r_s_t, r_m_u, r_m_t, r_h_u, r_h_t;
    logic       r_day;
    logic       w_tick, w_c_su, w_c_st, w_c_mu, w_c_mt, w_h_wrap, w_h_carry;
    logic [3:0] w_h_u_n, w_h_t_n, w_mi_u_n, w_mi_t_n;

    // Out-of-range digits compare as terminal, so they wrap to 0 on the next increment.
    function automatic logic [3:0] f_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    // A set button in the same cycle swallows the tick.
    assign w_tick    = bus.ENABLE_Hz & ~bus.HOLD & ~bus.INC_MIN & ~bus.INC_HOUR;
    assign w_c_su    = r_s_u >= 4'd9;
    assign w_c_st    = w_c_su & (r_s_t >= 4'd5);
    assign w_c_mu    = w_c_st & (r_m_u >= 4'd9);
    assign w_c_mt    = w_c_mu & (r_m_t >= 4'd5);
    assign w_h_wrap  = (r_h_t >= 4'd2) & (r_h_u >= 4'd3);
    assign w_h_carry = r_h_u >= 4'd9;
    assign w_h_u_n   = (w_h_wrap | w_h_carry) ? 4'd0 : r_h_u + 4'd1;
    assign w_h_t_n   = w_h_wrap ? 4'd0 : (w_h_carry ? f_inc(r_h_t, 4'd2) : r_h_t);
    assign w_mi_u_n  = f_inc(r_m_u, 4'd9);
    assign w_mi_t_n  = (r_m_u >= 4'd9) ? f_inc(r_m_t, 4'd5) : r_m_t;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_s_u <= 4'd0;
            r_s_t <= 4'd0;
            r_m_u <= INIT_MM[3:0];
            r_m_t <= INIT_MM[7:4];
            r_h_u <= INIT_HH[3:0];
            r_h_t <= INIT_HH[7:4];
            r_day <= 1'b0;
        end else begin
            r_day <= w_tick & w_c_mt & w_h_wrap;
            if (bus.INC_HOUR) begin
                r_h_u <= w_h_u_n;
                r_h_t <= w_h_t_n;
            end
            if (bus.INC_MIN) begin
                r_m_u <= w_mi_u_n;
                r_m_t <= w_mi_t_n;
                r_s_u <= 4'd0;
                r_s_t <= 4'd0;
            end
            if (w_tick) begin
                r_s_u <= f_inc(r_s_u, 4'd9);
                if (w_c_su) r_s_t <= f_inc(r_s_t, 4'd5);
                if (w_c_st) r_m_u <= f_inc(r_m_u, 4'd9);
                if (w_c_mu) r_m_t <= f_inc(r_m_t, 4'd5);
                if (w_c_mt) begin
                    r_h_u <= w_h_u_n;
                    r_h_t <= w_h_t_n;
                end
            end
        end
    end

    assign bus.L1        = bus.DISP_SEL ? r_s_u : r_m_u;
    assign bus.L2        = bus.DISP_SEL ? r_s_t : r_m_t;
    assign bus.L3        = bus.DISP_SEL ? r_m_u : r_h_u;
    assign bus.L4        = bus.DISP_SEL ? r_m_t : r_h_t;
    assign bus.COLON     = ~r_s_u[0];
    assign bus.DAY_PULSE = r_day;
endmodule
